// File: rtl/twiddle_sched_if.sv
// twiddle_sched_if
//   Groups the sample input stream, the twiddle ROM read request and the
//   multiplier-side outputs of one radix-2^2 SDF stage twiddle sequencer.
//   master : upstream/stimulus side (drives samples, observes outputs)
//   slave  : twiddle_sched itself
//   Signals:
//     in_valid, in_sop, in_re, in_im     sample stream into the sequencer
//     tw_addr, tw_rd                     twiddle ROM exponent address / strobe
//     mul_a_re, mul_a_im                 data aligned with ROM output
//     out_valid, out_sop, out_tw_one     flags aligned with multiplier output
//     sync_err                           sticky frame-misalignment flag
interface twiddle_sched_if #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6
);
  logic             in_valid;
  logic             in_sop;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic [LOG_N-1:0] tw_addr;
  logic             tw_rd;
  logic [WIDTH-1:0] mul_a_re;
  logic [WIDTH-1:0] mul_a_im;
  logic             out_valid;
  logic             out_sop;
  logic             out_tw_one;
  logic             sync_err;

  modport master (
    output in_valid, in_sop, in_re, in_im,
    input  tw_addr, tw_rd, mul_a_re, mul_a_im,
    input  out_valid, out_sop, out_tw_one, sync_err
  );

  modport slave (
    input  in_valid, in_sop, in_re, in_im,
    output tw_addr, tw_rd, mul_a_re, mul_a_im,
    output out_valid, out_sop, out_tw_one, sync_err
  );
endinterface

// File: rtl/twiddle_sched.sv
// twiddle_sched
//   Sequences the twiddle multiply of one radix-2^2 SDF stage. Tracks the
//   position m of each accepted sample inside the stage block (length
//   L = N >> 2*STAGE), derives the twiddle exponent e = (m mod L/4) * q'
//   with q' = {0,2,1,3}[m / (L/4)], and issues the ROM address e << 2*STAGE.
//   Sample data is delayed to meet the ROM output at the multiplier, and
//   valid / start-of-frame / unity-twiddle flags are delayed to meet the
//   multiplier output. All delay lines are free-running (no stall).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    twiddle_sched_if slave modport (see interface header)
module twiddle_sched #(
  parameter int WIDTH   = 16,
  parameter int LOG_N   = 6,
  parameter int STAGE   = 0,
  parameter int ROM_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  twiddle_sched_if.slave  bus
);

  localparam int unsigned LOGL   = LOG_N - 2 * STAGE;       // log2 of block length
  localparam int unsigned RW     = LOGL - 2;                // width of m mod L/4
  localparam int unsigned D_DATA = 1 + ROM_LAT;             // sample -> ROM data
  localparam int unsigned D_OUT  = 1 + ROM_LAT + MUL_LAT;   // sample -> multiplier out
  localparam logic [LOGL-1:0] R_MASK = LOGL'((1 << RW) - 1);

  // Position tracking and exponent generation
  logic [LOGL-1:0]  cnt_q, cnt_d;
  logic [LOGL-1:0]  m;
  logic [1:0]       q;
  logic [LOGL-1:0]  r;
  logic [LOGL-1:0]  e;
  logic [LOG_N-1:0] addr_d;
  logic             accept_sop;
  logic             tw_one_d;

  // Registered outputs and delay lines
  logic [LOG_N-1:0] tw_addr_q;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] re_pipe_q [D_DATA];
  logic [WIDTH-1:0] im_pipe_q [D_DATA];
  logic [D_OUT-1:0] vld_pipe_q;
  logic [D_OUT-1:0] sop_pipe_q;
  logic [D_OUT-1:0] one_pipe_q;

  always_comb begin
    // in_sop forces position 0 (also the resync path after misalignment)
    m          = bus.in_sop ? '0 : cnt_q;
    cnt_d      = bus.in_valid ? (m + LOGL'(1)) : cnt_q;
    accept_sop = bus.in_valid & bus.in_sop;
    sync_err_d = sync_err_q | (accept_sop & (cnt_q != '0));

    q = m[LOGL-1 -: 2];
    r = m & R_MASK;

    // e = r * q' with q' the bit-reversed quadrant index; r < L/4 so 3r fits
    unique case (q)
      2'd0:    e = '0;
      2'd1:    e = r << 1;
      2'd2:    e = r;
      default: e = (r << 1) + r;
    endcase

    addr_d   = LOG_N'(e) << (2 * STAGE);
    tw_one_d = bus.in_valid & (e == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tw_addr_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      // Address only moves on real reads, keeping the ROM bus quiet in gaps
      if (bus.in_valid) begin
        tw_addr_q <= addr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < D_DATA; i++) begin
        re_pipe_q[i] <= '0;
        im_pipe_q[i] <= '0;
      end
    end else begin
      re_pipe_q[0] <= bus.in_re;
      im_pipe_q[0] <= bus.in_im;
      for (int unsigned i = 1; i < D_DATA; i++) begin
        re_pipe_q[i] <= re_pipe_q[i-1];
        im_pipe_q[i] <= im_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      sop_pipe_q <= '0;
      one_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[D_OUT-2:0], bus.in_valid};
      sop_pipe_q <= {sop_pipe_q[D_OUT-2:0], accept_sop};
      one_pipe_q <= {one_pipe_q[D_OUT-2:0], tw_one_d};
    end
  end

  // The first valid tap doubles as the ROM read strobe
  assign bus.tw_addr    = tw_addr_q;
  assign bus.tw_rd      = vld_pipe_q[0];
  assign bus.mul_a_re   = re_pipe_q[D_DATA-1];
  assign bus.mul_a_im   = im_pipe_q[D_DATA-1];
  assign bus.out_valid  = vld_pipe_q[D_OUT-1];
  assign bus.out_sop    = sop_pipe_q[D_OUT-1];
  assign bus.out_tw_one = one_pipe_q[D_OUT-1];
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_twiddle_sched.sv
module tb_twiddle_sched;

  localparam int D1 = 2;  // sample -> mul_a (1 + ROM_LAT)
  localparam int D2 = 4;  // sample -> out_*  (1 + ROM_LAT + MUL_LAT)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sop;
  logic [15:0] in_re, in_im;

  int checks = 0;
  int errors = 0;
  int fc = 0;             // stimulus-side frame position (N = 64)

  always #5 clk = ~clk;

  twiddle_sched_if #(.WIDTH(16), .LOG_N(6)) b0 ();
  twiddle_sched_if #(.WIDTH(16), .LOG_N(6)) b1 ();

  assign b0.in_valid = in_valid;
  assign b0.in_sop   = in_sop;
  assign b0.in_re    = in_re;
  assign b0.in_im    = in_im;
  assign b1.in_valid = in_valid;
  assign b1.in_sop   = in_sop;
  assign b1.in_re    = in_re;
  assign b1.in_im    = in_im;

  twiddle_sched #(.WIDTH(16), .LOG_N(6), .STAGE(0), .ROM_LAT(1), .MUL_LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  twiddle_sched #(.WIDTH(16), .LOG_N(6), .STAGE(1), .ROM_LAT(1), .MUL_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic        sop;
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  a0;
    logic [5:0]  a1;
    logic        one0;
    logic        one1;
    int          m0;
    int          m1;
  } ent_t;

  ent_t hist [8];
  int   pos0 = 0, pos1 = 0;
  logic sync0 = 1'b0, sync1 = 1'b0;

  function automatic int exp_e(input int m, input int len);
    int l4, q, r, qp;
    l4 = len / 4;
    q  = m / l4;
    r  = m % l4;
    qp = (q == 1) ? 2 : (q == 2) ? 1 : q;
    return r * qp;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input logic rd, input logic [5:0] ad,
                     input logic [15:0] are, input logic [15:0] aim,
                     input logic ov, input logic os, input logic oo, input logic se);
    chk($sformatf("d%0d tw_rd", d), 32'(rd), 32'(hist[0].v));
    if (hist[0].v)
      chk($sformatf("d%0d tw_addr", d), 32'(ad), 32'(d == 0 ? hist[0].a0 : hist[0].a1));
    chk($sformatf("d%0d mul_a_re", d), 32'(are), 32'(hist[D1-1].re));
    chk($sformatf("d%0d mul_a_im", d), 32'(aim), 32'(hist[D1-1].im));
    chk($sformatf("d%0d out_valid", d), 32'(ov), 32'(hist[D2-1].v));
    chk($sformatf("d%0d out_sop", d), 32'(os), 32'(hist[D2-1].sop));
    chk($sformatf("d%0d out_tw_one", d), 32'(oo),
        32'(d == 0 ? hist[D2-1].one0 : hist[D2-1].one1));
    chk($sformatf("d%0d sync_err", d), 32'(se), 32'(d == 0 ? sync0 : sync1));
  endtask

  always @(negedge rst_n) begin
    for (int i = 0; i < 8; i++) hist[i] = '0;
    pos0  = 0;
    pos1  = 0;
    sync0 = 1'b0;
    sync1 = 1'b0;
  end

  always @(posedge clk) begin : mon
    ent_t n;
    n = '0;
    if (rst_n === 1'b1 && in_valid === 1'b1) begin
      n.v   = 1'b1;
      n.sop = in_sop;
      n.re  = in_re;
      n.im  = in_im;
      n.m0  = in_sop ? 0 : pos0;
      n.m1  = in_sop ? 0 : pos1;
      if (in_sop && pos0 != 0) sync0 = 1'b1;
      if (in_sop && pos1 != 0) sync1 = 1'b1;
      pos0  = (n.m0 + 1) % 64;
      pos1  = (n.m1 + 1) % 16;
      n.a0   = 6'(exp_e(n.m0, 64));
      n.a1   = 6'(exp_e(n.m1, 16) * 4);
      n.one0 = (exp_e(n.m0, 64) == 0);
      n.one1 = (exp_e(n.m1, 16) == 0);
    end else if (rst_n === 1'b1) begin
      n.re = in_re;
      n.im = in_im;
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = n;
    #1;
    cmp(0, b0.tw_rd, b0.tw_addr, b0.mul_a_re, b0.mul_a_im,
        b0.out_valid, b0.out_sop, b0.out_tw_one, b0.sync_err);
    cmp(1, b1.tw_rd, b1.tw_addr, b1.mul_a_re, b1.mul_a_im,
        b1.out_valid, b1.out_sop, b1.out_tw_one, b1.sync_err);
    // Hand-computed anchors for the model
    if (hist[0].v && hist[0].m0 == 20) chk("pin m20 addr", 32'(b0.tw_addr), 32'd8);
    if (hist[0].v && hist[0].m0 == 37) chk("pin m37 addr", 32'(b0.tw_addr), 32'd5);
    if (hist[0].v && hist[0].m0 == 63) chk("pin m63 addr", 32'(b0.tw_addr), 32'd45);
    if (hist[0].v && hist[0].m1 == 13) chk("pin s1 m13 addr", 32'(b1.tw_addr), 32'd12);
    if (hist[0].v && hist[0].m1 == 6)  chk("pin s1 m6 addr", 32'(b1.tw_addr), 32'd16);
    if (hist[D2-1].v && hist[D2-1].m0 == 16) chk("pin m16 one", 32'(b0.out_tw_one), 32'd1);
    if (hist[D2-1].v && hist[D2-1].m0 == 17) chk("pin m17 one", 32'(b0.out_tw_one), 32'd0);
    if (hist[D2-1].v && hist[D2-1].m0 == 48) chk("pin m48 one", 32'(b0.out_tw_one), 32'd1);
  end

  // ---------------- stimulus ----------------
  // Called at posedge+2; returns at posedge+2 after the sample was captured
  task automatic step(input logic v, input logic s);
    in_valid = v;
    in_sop   = v ? s : 1'($urandom_range(0, 1));
    in_re    = 16'($urandom);
    in_im    = 16'($urandom);
    @(posedge clk);
    #2;
  endtask

  task automatic samp(input logic v);
    step(v, v && fc == 0);
    if (v) fc = (fc + 1) % 64;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tw_addr0"}, 32'(b0.tw_addr), 32'd0);
    chk({tag, " tw_rd0"}, 32'(b0.tw_rd), 32'd0);
    chk({tag, " mul_re0"}, 32'(b0.mul_a_re), 32'd0);
    chk({tag, " out_valid0"}, 32'(b0.out_valid), 32'd0);
    chk({tag, " out_sop0"}, 32'(b0.out_sop), 32'd0);
    chk({tag, " sync_err0"}, 32'(b0.sync_err), 32'd0);
    chk({tag, " out_valid1"}, 32'(b1.out_valid), 32'd0);
    chk({tag, " sync_err1"}, 32'(b1.sync_err), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // One continuous frame m = 0..63 (four STAGE=1 blocks)
    for (int i = 0; i < 64; i++) samp(1'b1);

    // Gapped valid pattern
    samp(1'b1); samp(1'b0); samp(1'b0); samp(1'b1);
    samp(1'b1); samp(1'b0); samp(1'b1);

    // Random gaps, back-to-back frames with in_sop every 64th sample
    for (int i = 0; i < 400; i++) samp(1'($urandom_range(0, 3) != 0));

    // Misaligned in_sop at position 10
    while (fc != 10) samp(1'($urandom_range(0, 1)));
    step(1'b1, 1'b1);
    fc = 1;
    chk("sync set", 32'(b0.sync_err), 32'd1);
    chk("resync addr", 32'(b0.tw_addr), 32'd0);
    for (int i = 0; i < 5; i++) samp(1'b1);
    chk("sync sticky", 32'(b0.sync_err), 32'd1);

    // Reset pulse mid-frame around m = 30
    while (fc != 31) samp(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    fc = 1;
    chk("post-rst addr", 32'(b0.tw_addr), 32'd0);
    chk("post-rst sync", 32'(b0.sync_err), 32'd0);

    // More frames after reset
    for (int i = 0; i < 300; i++) samp(1'($urandom_range(0, 4) != 0));
    for (int i = 0; i < 8; i++) samp(1'b0);
    chk("final sync0", 32'(b0.sync_err), 32'd0);
    chk("final sync1", 32'(b1.sync_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
